// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 16-bit 5-stage core: pipeline-register enables,
// flush/bubble, EX forwarding selects, halt-drain FSM and a saturating stall counter.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_Rs,
  input  logic [3:0]       ID_Rt,
  input  logic             ID_uses_Rs,
  input  logic             ID_uses_Rt,
  input  logic             ID_halt,
  input  logic [3:0]       EX_Rs,
  input  logic [3:0]       EX_Rt,
  input  logic [3:0]       EX_dstReg,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic [3:0]       MEM_Rd,
  input  logic             MEM_RegWrite,
  input  logic [3:0]       WB_Rd,
  input  logic             WB_RegWrite,
  input  logic             WB_halt,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state;
  logic   lu;
  logic   stall_event;
  logic   unused_ex_regwrite;

  // A load always writes its destination, so the load-use test needs only MemRead.
  assign unused_ex_regwrite = EX_RegWrite;

  // Debug view of the FSM: 0 = RUN, 1 = DRAIN, 2 = HALTED.
  assign dbg_state = state;

  assign lu = EX_MemRead && (EX_dstReg != 4'd0) &&
              ((ID_uses_Rs && (ID_Rs == EX_dstReg)) ||
               (ID_uses_Rt && (ID_Rt == EX_dstReg)));

  assign stall_event = dmem_busy || lu || imem_busy || EX_branch_taken;

  // The younger producer (EX/MEM) wins over MEM/WB; R0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (MEM_RegWrite && (MEM_Rd != 4'd0) && (MEM_Rd == EX_Rs))
        fwd_a = 2'b10;
      else if (WB_RegWrite && (WB_Rd != 4'd0) && (WB_Rd == EX_Rs))
        fwd_a = 2'b01;
      if (MEM_RegWrite && (MEM_Rd != 4'd0) && (MEM_Rd == EX_Rt))
        fwd_b = 2'b10;
      else if (WB_RegWrite && (WB_Rd != 4'd0) && (WB_Rd == EX_Rt))
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      case (state)
        S_RUN: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          if (dmem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
          end else if (EX_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (ID_halt || imem_busy) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        S_DRAIN: begin
          // Front end is sealed off with NOPs while older instructions retire.
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_write  = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_write = !dmem_busy;
          mem_wb_write = !dmem_busy;
        end
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      stall_cycles <= '0;
    end else begin
      case (state)
        S_RUN:
          if (!dmem_busy && !EX_branch_taken && !lu && ID_halt)
            state <= S_DRAIN;
        S_DRAIN:
          if (WB_halt)
            state <= S_HALTED;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
      if ((state != S_HALTED) && stall_event && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic,
// all checked every cycle against a rule-level model of the controller.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_dstReg, MEM_Rd, WB_Rd;
  logic ID_uses_Rs, ID_uses_Rt, ID_halt, EX_RegWrite, EX_MemRead, EX_branch_taken;
  logic MEM_RegWrite, WB_RegWrite, WB_halt, imem_busy, dmem_busy;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, mem_wb_write, halted;
  logic [1:0] fwd_a, fwd_b, dbg_state;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // Model state (spec-level, independent of the RTL encoding).
  int m_state = M_RUN;
  int m_cnt = 0;
  int m_state_nxt = M_RUN;
  int m_cnt_nxt = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rs(ID_uses_Rs), .ID_uses_Rt(ID_uses_Rt),
    .ID_halt(ID_halt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_dstReg(EX_dstReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_branch_taken(EX_branch_taken),
    .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_Rd(WB_Rd),
    .WB_RegWrite(WB_RegWrite), .WB_halt(WB_halt),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Newest producer first; first matching non-R0 writer supplies the operand.
  function automatic int fwd_of(input int src);
    int rd_list[2];
    int wr_list[2];
    int sel_list[2];
    rd_list  = '{int'(MEM_Rd), int'(WB_Rd)};
    wr_list  = '{int'(MEM_RegWrite), int'(WB_RegWrite)};
    sel_list = '{2, 1};
    for (int i = 0; i < 2; i++)
      if (wr_list[i] == 1 && rd_list[i] != 0 && rd_list[i] == src) return sel_list[i];
    return 0;
  endfunction

  // ---------------- model + compare (every cycle) ----------------
  always @(negedge clk) begin
    int e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl, e_bb, e_h, e_fa, e_fb;
    bit m_lu, stalled;
    e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
    e_fl = 0; e_bb = 0; e_h = 0; e_fa = 0; e_fb = 0;
    m_lu = EX_MemRead && EX_dstReg != 0 &&
           ((ID_uses_Rs && ID_Rs == EX_dstReg) || (ID_uses_Rt && ID_Rt == EX_dstReg));
    if (!rst) begin
      e_fa = fwd_of(int'(EX_Rs));
      e_fb = fwd_of(int'(EX_Rt));
      if (m_state == M_RUN) begin
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {5{32'd1}};
        if (dmem_busy) {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = '0;
        else if (EX_branch_taken) begin e_fl = 1; e_bb = 1; end
        else if (m_lu) begin e_pc = 0; e_ifid = 0; e_bb = 1; end
        else if (ID_halt || imem_busy) begin e_pc = 0; e_fl = 1; end
      end else if (m_state == M_DRAIN) begin
        e_ifid = 1; e_idex = 1; e_fl = 1; e_bb = 1;
        e_exmem = dmem_busy ? 0 : 1;
        e_memwb = dmem_busy ? 0 : 1;
      end else begin
        e_h = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("if_id_write", if_id_write, e_ifid);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_write", id_ex_write, e_idex);
    chk("id_ex_bubble", id_ex_bubble, e_bb);
    chk("ex_mem_write", ex_mem_write, e_exmem);
    chk("mem_wb_write", mem_wb_write, e_memwb);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("halted", halted, e_h);
    chk("stall_cycles", stall_cycles, m_cnt);
    chk("state", dbg_state, m_state);

    stalled = dmem_busy || m_lu || imem_busy || EX_branch_taken;
    m_state_nxt = m_state;
    m_cnt_nxt = m_cnt;
    if (rst) begin
      m_state_nxt = M_RUN;
      m_cnt_nxt = 0;
    end else begin
      if (m_state == M_RUN && !dmem_busy && !EX_branch_taken && !m_lu && ID_halt)
        m_state_nxt = M_DRAIN;
      else if (m_state == M_DRAIN && WB_halt)
        m_state_nxt = M_HALTED;
      if (m_state != M_HALTED && stalled && m_cnt < CNT_MAX) m_cnt_nxt = m_cnt + 1;
    end
  end

  always @(posedge clk) begin
    m_state = m_state_nxt;
    m_cnt = m_cnt_nxt;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    {ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_dstReg, MEM_Rd, WB_Rd} = '0;
    {ID_uses_Rs, ID_uses_Rt, ID_halt, EX_RegWrite, EX_MemRead, EX_branch_taken} = '0;
    {MEM_RegWrite, WB_RegWrite, WB_halt, imem_busy, dmem_busy} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  // HLT enters ID, then a token walks EX -> MEM -> WB; dmem_busy freezes it in MEM.
  task automatic drain_run(input int busy_cycles);
    int pos, busy_left, n;
    bit seen;
    do_reset();
    ID_halt = 1'b1;
    @(negedge clk);
    chk("halt_entry_pc_write", pc_write, 0);
    chk("halt_entry_flush", if_id_flush, 1);
    step();
    clear_inputs();
    pos = 1;
    busy_left = busy_cycles;
    n = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      WB_halt = (pos == 3);
      dmem_busy = (pos == 2 && busy_left > 0);
      @(negedge clk);
      if (halted) begin
        seen = 1;
        n = i;
        chk("halted_writes", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 0);
      end else begin
        if (dmem_busy) busy_left--;
        else if (pos < 3) pos++;
        step();
      end
    end
    chk("drain_seen_halt", seen, 1);
    chk("drain_length", n, 3 + busy_cycles);
    step();
    clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    @(negedge clk);
    chk("reset_pc_write", pc_write, 0);
    chk("reset_halted", halted, 0);

    // LDR R3 ; ADD R4,R3,R5
    do_reset();
    ID_Rs = 4'd3; ID_uses_Rs = 1; ID_Rt = 4'd5; ID_uses_Rt = 1;
    EX_dstReg = 4'd3; EX_MemRead = 1; EX_RegWrite = 1;
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_if_id_write", if_id_write, 0);
    step();
    EX_dstReg = 0; EX_MemRead = 0; EX_RegWrite = 0; MEM_Rd = 4'd3; MEM_RegWrite = 1;
    @(negedge clk);
    chk("lu_single_bubble", id_ex_bubble, 0);
    chk("lu_stall_count", stall_cycles, 1);
    step();
    clear_inputs();
    EX_Rs = 4'd3; EX_Rt = 4'd5; EX_dstReg = 4'd4; EX_RegWrite = 1;
    WB_Rd = 4'd3; WB_RegWrite = 1;
    @(negedge clk);
    chk("lu_fwd_a_wb", fwd_a, 2'b01);
    chk("lu_fwd_b_none", fwd_b, 2'b00);
    chk("lu_stall_after", stall_cycles, 1);

    // ADD R2 ; SUB R6,R2,R2
    step();
    clear_inputs();
    EX_Rs = 4'd2; EX_Rt = 4'd2; MEM_Rd = 4'd2; MEM_RegWrite = 1;
    @(negedge clk);
    chk("exmem_fwd_a", fwd_a, 2'b10);
    chk("exmem_fwd_b", fwd_b, 2'b10);
    chk("exmem_no_stall", pc_write, 1);
    step();
    WB_Rd = 4'd2; WB_RegWrite = 1;
    @(negedge clk);
    chk("exmem_beats_wb_a", fwd_a, 2'b10);
    chk("exmem_beats_wb_b", fwd_b, 2'b10);

    // R0 is never forwarded
    step();
    clear_inputs();
    MEM_Rd = 0; MEM_RegWrite = 1; WB_Rd = 0; WB_RegWrite = 1;
    @(negedge clk);
    chk("r0_fwd_a", fwd_a, 2'b00);

    // Branch squashes a halt in ID
    step();
    clear_inputs();
    EX_branch_taken = 1; ID_halt = 1;
    @(negedge clk);
    chk("br_flush", if_id_flush, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_write", pc_write, 1);
    step();
    clear_inputs();
    @(negedge clk);
    chk("br_stays_run", dbg_state, 0);

    drain_run(0);
    drain_run(4);

    // Counter saturation
    do_reset();
    dmem_busy = 1;
    repeat (70000) step();
    @(negedge clk);
    chk("sat_value", stall_cycles, 16'hFFFF);
    step();
    @(negedge clk);
    chk("sat_no_wrap", stall_cycles, 16'hFFFF);

    // Reset in the middle of a drain
    step();
    clear_inputs();
    ID_halt = 1;
    step();
    clear_inputs();
    @(negedge clk);
    chk("mid_drain_state", dbg_state, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_drain_state", dbg_state, 0);
    chk("rst_drain_count", stall_cycles, 0);
    chk("rst_drain_halted", halted, 0);
    chk("rst_drain_pc_write", pc_write, 1);

    // Randomized traffic, small register space to provoke matches
    step();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      ID_Rs = 4'($urandom_range(0, 3)); ID_Rt = 4'($urandom_range(0, 3));
      EX_Rs = 4'($urandom_range(0, 3)); EX_Rt = 4'($urandom_range(0, 3));
      EX_dstReg = 4'($urandom_range(0, 3));
      MEM_Rd = 4'($urandom_range(0, 3)); WB_Rd = 4'($urandom_range(0, 3));
      ID_uses_Rs = 1'($urandom_range(0, 1)); ID_uses_Rt = 1'($urandom_range(0, 1));
      EX_RegWrite = 1'($urandom_range(0, 1)); EX_MemRead = ($urandom_range(0, 3) == 0);
      MEM_RegWrite = 1'($urandom_range(0, 1)); WB_RegWrite = 1'($urandom_range(0, 1));
      ID_halt = ($urandom_range(0, 15) == 0);
      WB_halt = ($urandom_range(0, 7) == 0);
      EX_branch_taken = ($urandom_range(0, 7) == 0);
      imem_busy = ($urandom_range(0, 7) == 0);
      dmem_busy = ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 0;
    clear_inputs();
    step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
